// File: rtl/dlx_pkg.sv
// DLX fetch-stage shared definitions.
// Opcodes, FSM states and the instruction width.
package dlx_pkg;

  localparam int INSTR_W = 32;

  typedef logic [5:0] opcode_t;

  localparam opcode_t OP_J    = 6'd2;
  localparam opcode_t OP_JAL  = 6'd3;
  localparam opcode_t OP_BEQZ = 6'd4;
  localparam opcode_t OP_BNEZ = 6'd5;
  localparam opcode_t OP_JR   = 6'd18;
  localparam opcode_t OP_JALR = 6'd19;

  typedef enum logic [1:0] {
    ST_RST,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } fetch_state_e;

  function automatic opcode_t opcode_of(
    input logic [INSTR_W-1:0] w
  );
    return w[31:26];
  endfunction

endpackage

// File: rtl/dlx_next_pc.sv
// DLX next-PC selection (combinational).
// In: pc, instruction, branch, jump, rs1_val. Out: next_pc, misalign.
module dlx_next_pc
  import dlx_pkg::*;
(
  input  logic [31:0]        pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               branch,
  input  logic               jump,
  input  logic [31:0]        rs1_val,
  output logic [31:0]        next_pc,
  output logic               misalign
);

  opcode_t     op;
  logic [31:0] seq_pc;
  logic [31:0] rel26;
  logic [31:0] rel16;
  logic        rs1_zero;
  logic        is_jrel;
  logic        is_jreg;
  logic        is_btaken;

  always_comb begin
    op       = opcode_of(instruction);
    seq_pc   = pc + 32'd4;
    rel26    = seq_pc
             + {{6{instruction[25]}}, instruction[25:0]};
    rel16    = seq_pc
             + {{16{instruction[15]}}, instruction[15:0]};
    rs1_zero = (rs1_val == 32'd0);
    is_jrel  = jump && (op == OP_J || op == OP_JAL);
    is_jreg  = jump && (op == OP_JR || op == OP_JALR);
    // jump overrides branch, so branch only counts when jump is low
    is_btaken = !jump && branch &&
                ((op == OP_BEQZ && rs1_zero) ||
                 (op == OP_BNEZ && !rs1_zero));
    next_pc = seq_pc;
    unique case (1'b1)
      is_jrel:   next_pc = rel26;
      is_jreg:   next_pc = rs1_val;
      is_btaken: next_pc = rel16;
      default:   next_pc = seq_pc;
    endcase
    misalign = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/dlx_fetch.sv
// DLX instruction-fetch stage: PC, imem req/ack, instruction register.
// Ports: clk/reset, imem_req/addr/rdata/ack, instruction, instr_valid,
// pc, link_pc, branch, jump, rs1_val, advance, fault.
module dlx_fetch
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        link_pc,
  input  logic               branch,
  input  logic               jump,
  input  logic [31:0]        rs1_val,
  input  logic               advance,
  output logic               fault
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               fault_q, fault_d;

  logic [31:0] next_pc;
  logic        misalign;

  dlx_next_pc u_next_pc (
    .pc          (pc_q),
    .instruction (instr_q),
    .branch      (branch),
    .jump        (jump),
    .rs1_val     (rs1_val),
    .next_pc     (next_pc),
    .misalign    (misalign)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (advance) begin
          valid_d = 1'b0;
          if (misalign) begin
            // pc stays on the offending instruction
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign link_pc     = pc_q + 32'd4;
  assign fault       = fault_q;

endmodule

// File: tb/tb_dlx_fetch.sv
// Self-checking bench for dlx_fetch.
// Directed scenarios plus a randomized run against a PC model.
module tb_dlx_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_ack = 1'b0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] link_pc;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] rs1_val = 32'd0;
  logic        advance = 1'b0;
  logic        fault;

  int checks = 0;
  int failures = 0;

  dlx_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .link_pc     (link_pc),
    .branch      (branch),
    .jump        (jump),
    .rs1_val     (rs1_val),
    .advance     (advance),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Reference next-PC: DLX control-flow rules in plain arithmetic.
  function automatic logic [31:0] ref_next(
    input logic [31:0] cur, input logic [31:0] ins,
    input logic br, input logic jp, input logic [31:0] rs1
  );
    int unsigned op;
    int off;
    logic [31:0] seq;
    op  = ins[31:26];
    seq = cur + 4;
    if (jp) begin
      if (op == 2 || op == 3) begin
        off = $signed(ins[25:0]);
        return seq + off;
      end
      if (op == 18 || op == 19) return rs1;
      return seq;
    end
    if (br) begin
      off = $signed(ins[15:0]);
      if (op == 4 && rs1 == 0) return seq + off;
      if (op == 5 && rs1 != 0) return seq + off;
    end
    return seq;
  endfunction

  // All stepping tasks begin and end just after a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_req(output bit to);
    to = 1'b0;
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    if (!imem_req) to = 1'b1;
  endtask

  task automatic do_fetch(input logic [31:0] word, input int lat,
                          output logic [31:0] addr, output bit to);
    wait_req(to);
    addr = imem_addr;
    if (to) return;
    repeat (lat) begin
      imem_rdata = $urandom;
      @(negedge clk);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic advance_step(input logic br, input logic jp,
                              input logic [31:0] rs1);
    branch  = br;
    jump    = jp;
    rs1_val = rs1;
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    branch  = 1'b0;
    jump    = 1'b0;
    rs1_val = $urandom;
  endtask

  // Reset, then a single j from pc 0 lands on target.
  task automatic goto_pc(input logic [31:0] target, output bit to);
    logic [31:0] a;
    logic [31:0] off;
    do_reset();
    off = target - 32'd4;
    do_fetch({6'd2, off[25:0]}, 0, a, to);
    if (!to) advance_step(1'b0, 1'b1, 32'd0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 32'd0) begin
      failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'd0);
    end
    checks++;
    if (instruction !== 32'd0) begin
      failures++; $display("FAIL reset_instr got=%h exp=0", instruction);
    end
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got v=%b r=%b f=%b exp=000",
               instr_valid, imem_req, fault);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    logic [31:0] w;
    bit to;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w = {6'd0, 26'($urandom)};
      do_fetch(w, 0, a, to);
      checks++;
      if (to || a !== 32'(4 * i)) begin
        failures++;
        $display("FAIL seq_addr got=%h exp=%h to=%0d", a, 32'(4 * i), to);
      end
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 ||
          instruction !== w || link_pc !== 32'(4 * i + 4)) begin
        failures++;
        $display("FAIL seq_exec got v=%b r=%b i=%h l=%h exp v=1 r=0 i=%h",
                 instr_valid, imem_req, instruction, link_pc, w);
      end
      advance_step(1'b0, 1'b0, 32'd0);
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
        failures++;
        $display("FAIL seq_refetch got v=%b r=%b exp v=0 r=1",
                 instr_valid, imem_req);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] a;
    logic [31:0] rs [2];
    logic [31:0] ex [2];
    bit to;
    rs[0] = 32'd0; ex[0] = 32'h3C;
    rs[1] = 32'd5; ex[1] = 32'h44;
    for (int k = 0; k < 2; k++) begin
      goto_pc(32'h40, to);
      do_fetch({6'd4, 5'd1, 5'd0, 16'hFFF8}, 1, a, to);
      checks++;
      if (to || a !== 32'h40) begin
        failures++; $display("FAIL beqz_pc got=%h exp=40 to=%0d", a, to);
      end
      advance_step(1'b1, 1'b0, rs[k]);
      wait_req(to);
      checks++;
      if (to || imem_addr !== ex[k]) begin
        failures++;
        $display("FAIL beqz_target got=%h exp=%h", imem_addr, ex[k]);
      end
    end
  endtask

  task automatic test_fault();
    logic [31:0] a;
    bit to;
    bit saw_req;
    do_reset();
    do_fetch({6'd18, 5'd3, 21'd0}, 0, a, to);
    advance_step(1'b0, 1'b1, 32'h0000_0102);
    checks++;
    if (fault !== 1'b1 || imem_req !== 1'b0 ||
        instr_valid !== 1'b0 || pc !== 32'd0) begin
      failures++;
      $display("FAIL jr_fault got f=%b r=%b v=%b pc=%h exp f=1 r=0 v=0 pc=0",
               fault, imem_req, instr_valid, pc);
    end
    saw_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      imem_ack = 1'($urandom);
      advance  = 1'b1;
      @(negedge clk);
      if (imem_req || !fault) saw_req = 1'b1;
    end
    imem_ack = 1'b0;
    advance  = 1'b0;
    checks++;
    if (saw_req) begin
      failures++; $display("FAIL halt_hold got=req_or_nofault exp=quiet");
    end
    do_reset();
    checks++;
    if (fault !== 1'b0 || pc !== 32'd0) begin
      failures++;
      $display("FAIL halt_reset got f=%b pc=%h exp f=0 pc=0", fault, pc);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    logic [31:0] w;
    bit to;
    bit bad;
    goto_pc(32'h200, to);
    w = {6'd5, 5'd2, 5'd0, 16'h0010};
    do_fetch(w, 2, a, to);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      branch  = 1'($urandom);
      jump    = 1'($urandom);
      rs1_val = $urandom;
      @(negedge clk);
      if (pc !== 32'h200 || instruction !== w ||
          instr_valid !== 1'b1 || imem_req !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL stall_hold got pc=%h i=%h v=%b r=%b exp pc=200 i=%h",
               pc, instruction, instr_valid, imem_req, w);
    end
    advance_step(1'b1, 1'b0, 32'd7);
    checks++;
    if (pc !== 32'h214) begin
      failures++; $display("FAIL stall_bnez got=%h exp=214", pc);
    end
  endtask

  task automatic test_reset_midfetch();
    logic [31:0] a;
    bit to;
    do_reset();
    wait_req(to);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instruction !== 32'd0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL midfetch_drop got i=%h v=%b exp i=0 v=0",
               instruction, instr_valid);
    end
    do_fetch(32'h0000_1234, 0, a, to);
    checks++;
    if (to || a !== 32'd0 || instruction !== 32'h0000_1234) begin
      failures++;
      $display("FAIL midfetch_restart got a=%h i=%h exp a=0 i=1234",
               a, instruction);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    bit to;
    goto_pc(32'hFFFF_FFFC, to);
    do_fetch(32'h0000_0001, 0, a, to);
    checks++;
    if (to || a !== 32'hFFFF_FFFC || link_pc !== 32'd0) begin
      failures++;
      $display("FAIL wrap_pc got a=%h l=%h exp a=fffffffc l=0", a, link_pc);
    end
    advance_step(1'b0, 1'b0, 32'd0);
    wait_req(to);
    checks++;
    if (to || imem_addr !== 32'd0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL wrap_next got a=%h f=%b exp a=0 f=0", imem_addr, fault);
    end
  endtask

  task automatic test_random();
    logic [31:0] mpc;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] rs;
    logic [31:0] exp;
    logic [5:0]  op;
    logic        br;
    logic        jp;
    bit          to;
    logic [5:0]  ops [8];
    ops[0] = 6'd0;  ops[1] = 6'd2;  ops[2] = 6'd3;  ops[3] = 6'd4;
    ops[4] = 6'd5;  ops[5] = 6'd18; ops[6] = 6'd19; ops[7] = 6'd8;
    do_reset();
    mpc = 32'd0;
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(7)];
      w  = {op, 26'($urandom)};
      if ($urandom_range(7) != 0) w[1:0] = 2'b00;
      rs = $urandom;
      if ($urandom_range(7) != 0) rs[1:0] = 2'b00;
      if ($urandom_range(1) == 0) rs = 32'd0;
      jp = (op == 2 || op == 3 || op == 18 || op == 19);
      br = (op == 4 || op == 5);
      if ($urandom_range(5) == 0) begin
        jp = 1'($urandom);
        br = 1'($urandom);
      end
      do_fetch(w, $urandom_range(3), a, to);
      checks++;
      if (to || a !== mpc) begin
        failures++;
        $display("FAIL rnd_addr n=%0d got=%h exp=%h to=%0d", n, a, mpc, to);
      end
      checks++;
      if (instruction !== w || link_pc !== mpc + 32'd4) begin
        failures++;
        $display("FAIL rnd_ir n=%0d got i=%h l=%h exp i=%h l=%h",
                 n, instruction, link_pc, w, mpc + 32'd4);
      end
      repeat ($urandom_range(2)) @(negedge clk);
      exp = ref_next(mpc, w, br, jp, rs);
      advance_step(br, jp, rs);
      checks++;
      if (exp[1:0] != 2'b00) begin
        if (fault !== 1'b1 || pc !== mpc || imem_req !== 1'b0) begin
          failures++;
          $display("FAIL rnd_fault n=%0d got f=%b pc=%h exp f=1 pc=%h",
                   n, fault, pc, mpc);
        end
        do_reset();
        mpc = 32'd0;
      end else begin
        if (pc !== exp || fault !== 1'b0) begin
          failures++;
          $display("FAIL rnd_next n=%0d got pc=%h f=%b exp pc=%h f=0",
                   n, pc, fault, exp);
        end
        mpc = exp;
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_fault();
    test_stall();
    test_reset_midfetch();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
